// File: rtl/utim64_irq_sched.sv
// Interrupt scheduler for the four user-timer comparator lines.
// Edge capture, masking, fixed/round-robin arbitration, valid/ack handshake.
module utim64_irq_sched (
  input  logic       iTIMER_CLOCK,
  input  logic       inRESET,
  input  logic [3:0] iIRQ,
  input  logic [3:0] iMASK,
  input  logic       iRR_MODE,
  output logic       oIRQ_VALID,
  output logic [1:0] oIRQ_NUM,
  input  logic       iIRQ_ACK,
  output logic [3:0] oPENDING,
  output logic [3:0] oOVERFLOW,
  input  logic       iOVF_CLEAR
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_ACK = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] prev_q;
  logic [3:0] pend_q, pend_d;
  logic [3:0] ovf_q, ovf_d;
  logic [1:0] num_q, num_d;
  logic [1:0] last_q, last_d;

  logic [3:0] edge_v;
  logic [3:0] clr;
  logic [3:0] cand;
  logic       ack_ok;
  logic [1:0] win;
  logic [1:0] idx;

  assign edge_v = iIRQ & ~prev_q;
  assign ack_ok = (state_q == WAIT_ACK) & iIRQ_ACK;
  assign clr    = ack_ok ? (4'b0001 << num_q) : 4'b0000;
  assign cand   = pend_q & ~iMASK;

  // Descending scans so the highest-priority hit is assigned last.
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    if (!iRR_MODE) begin
      for (int i = 3; i >= 0; i--) begin
        if (cand[i]) win = 2'(i);
      end
    end else begin
      for (int i = 4; i >= 1; i--) begin
        idx = last_q + 2'(i);
        if (cand[idx]) win = idx;
      end
    end
  end

  always_comb begin
    pend_d  = (pend_q & ~clr) | edge_v;
    ovf_d   = (iOVF_CLEAR ? 4'b0000 : ovf_q)
            | (edge_v & pend_q & ~clr);
    state_d = state_q;
    num_d   = num_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (cand != 4'b0000) begin
          num_d   = win;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (iIRQ_ACK) begin
          last_d  = num_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iTIMER_CLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= IDLE;
      prev_q  <= 4'b0000;
      pend_q  <= 4'b0000;
      ovf_q   <= 4'b0000;
      num_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      prev_q  <= iIRQ;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      num_q   <= num_d;
      last_q  <= last_d;
    end
  end

  assign oIRQ_VALID = (state_q == WAIT_ACK);
  assign oIRQ_NUM   = num_q;
  assign oPENDING   = pend_q;
  assign oOVERFLOW  = ovf_q;

endmodule

// File: tb/tb_utim64_irq_sched.sv
// Bench for utim64_irq_sched: vector table through a scoreboard
// queue, plus hand-written reset sequences.
module tb_utim64_irq_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] irq;
  logic [3:0] mask;
  logic       rr;
  logic       valid;
  logic [1:0] num;
  logic       ack;
  logic [3:0] pend;
  logic [3:0] ovf;
  logic       oclr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] irq;
    logic [3:0] mask;
    logic       rr;
    logic       ack;
    logic       oclr;
    logic       ev;
    logic [1:0] en;
    logic [3:0] ep;
    logic [3:0] eo;
  } vec_t;

  vec_t        vq[$];
  logic [10:0] exp_q[$];

  utim64_irq_sched dut (
    .iTIMER_CLOCK(clk),
    .inRESET(rst_n),
    .iIRQ(irq),
    .iMASK(mask),
    .iRR_MODE(rr),
    .oIRQ_VALID(valid),
    .oIRQ_NUM(num),
    .iIRQ_ACK(ack),
    .oPENDING(pend),
    .oOVERFLOW(ovf),
    .iOVF_CLEAR(oclr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(
    input logic [3:0] i, input logic [3:0] m,
    input logic r, input logic a, input logic c,
    input logic v, input logic [1:0] n,
    input logic [3:0] p, input logic [3:0] o);
    vec_t t;
    t.irq = i; t.mask = m; t.rr = r; t.ack = a; t.oclr = c;
    t.ev = v; t.en = n; t.ep = p; t.eo = o;
    vq.push_back(t);
  endtask

  task automatic check(input string name,
                       input logic [10:0] exp);
    logic [10:0] got;
    got = {valid, num, pend, ovf};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got v=%b n=%0d p=%b o=%b want v=%b n=%0d p=%b o=%b",
               name, got[10], got[9:8], got[7:4], got[3:0],
               exp[10], exp[9:8], exp[7:4], exp[3:0]);
    end
  endtask

  initial begin
    logic [10:0] e;
    rst_n = 1'b0;
    irq = '0; mask = '0; rr = 1'b0; ack = 1'b0; oclr = 1'b0;

    // single event on source 2
    add(4'b0100, 4'h0, 0, 0, 0, 0, 0, 4'b0100, 4'h0);
    add(4'b0000, 4'h0, 0, 0, 0, 1, 2, 4'b0100, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 2, 4'b0000, 4'h0);
    // fixed priority, ack held high
    add(4'b1111, 4'h0, 0, 1, 0, 0, 2, 4'b1111, 4'h0);
    add(4'b1111, 4'h0, 0, 1, 0, 1, 0, 4'b1111, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 0, 4'b1110, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 1, 1, 4'b1110, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 1, 4'b1100, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 1, 2, 4'b1100, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 2, 4'b1000, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 1, 3, 4'b1000, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 3, 4'b0000, 4'h0);
    // grant 2 so the RR pointer sits at 2
    add(4'b0100, 4'h0, 0, 0, 0, 0, 3, 4'b0100, 4'h0);
    add(4'b0000, 4'h0, 0, 0, 0, 1, 2, 4'b0100, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 2, 4'b0000, 4'h0);
    // round-robin: order 3,0,1
    add(4'b1011, 4'h0, 1, 0, 0, 0, 2, 4'b1011, 4'h0);
    add(4'b0000, 4'h0, 1, 0, 0, 1, 3, 4'b1011, 4'h0);
    add(4'b0000, 4'h0, 1, 1, 0, 0, 3, 4'b0011, 4'h0);
    add(4'b0000, 4'h0, 1, 1, 0, 1, 0, 4'b0011, 4'h0);
    add(4'b0000, 4'h0, 1, 1, 0, 0, 0, 4'b0010, 4'h0);
    add(4'b0000, 4'h0, 1, 1, 0, 1, 1, 4'b0010, 4'h0);
    add(4'b0000, 4'h0, 1, 1, 0, 0, 1, 4'b0000, 4'h0);
    // mask holds off source 0; masking after grant does not withdraw
    add(4'b0001, 4'h1, 0, 0, 0, 0, 1, 4'b0001, 4'h0);
    add(4'b0000, 4'h1, 0, 0, 0, 0, 1, 4'b0001, 4'h0);
    add(4'b0000, 4'h1, 0, 0, 0, 0, 1, 4'b0001, 4'h0);
    add(4'b0000, 4'h0, 0, 0, 0, 1, 0, 4'b0001, 4'h0);
    add(4'b0000, 4'h1, 0, 0, 0, 1, 0, 4'b0001, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 0, 4'b0000, 4'h0);
    // overflow on source 1, sticky through ack, then cleared
    add(4'b0010, 4'h0, 0, 0, 0, 0, 0, 4'b0010, 4'h0);
    add(4'b0000, 4'h0, 0, 0, 0, 1, 1, 4'b0010, 4'h0);
    add(4'b0010, 4'h0, 0, 0, 0, 1, 1, 4'b0010, 4'b0010);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 1, 4'b0000, 4'b0010);
    add(4'b0000, 4'h0, 0, 0, 1, 0, 1, 4'b0000, 4'b0000);
    // edge in the same cycle as its ack: stays pending, no overflow
    add(4'b0010, 4'h0, 0, 0, 0, 0, 1, 4'b0010, 4'h0);
    add(4'b0000, 4'h0, 0, 0, 0, 1, 1, 4'b0010, 4'h0);
    add(4'b0010, 4'h0, 0, 1, 0, 0, 1, 4'b0010, 4'h0);
    add(4'b0000, 4'h0, 0, 0, 0, 1, 1, 4'b0010, 4'h0);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 1, 4'b0000, 4'h0);
    // overflow set beats a simultaneous clear
    add(4'b0100, 4'h0, 0, 0, 0, 0, 1, 4'b0100, 4'h0);
    add(4'b0000, 4'h0, 0, 0, 0, 1, 2, 4'b0100, 4'h0);
    add(4'b0100, 4'h0, 0, 0, 1, 1, 2, 4'b0100, 4'b0100);
    add(4'b0000, 4'h0, 0, 1, 0, 0, 2, 4'b0000, 4'b0100);
    add(4'b0000, 4'h0, 0, 0, 1, 0, 2, 4'b0000, 4'b0000);

    #12;
    check("reset_state", 11'b0);
    #10;
    rst_n = 1'b1;
    #1;

    foreach (vq[k]) begin
      irq  = vq[k].irq;
      mask = vq[k].mask;
      rr   = vq[k].rr;
      ack  = vq[k].ack;
      oclr = vq[k].oclr;
      exp_q.push_back({vq[k].ev, vq[k].en, vq[k].ep, vq[k].eo});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("vec%0d", k), e);
    end
    irq = '0; mask = '0; rr = 1'b0; ack = 1'b0; oclr = 1'b0;

    // reset mid-handshake
    irq = 4'b1000;
    @(posedge clk); #1;
    check("rst_pre_pend", {1'b0, 2'd2, 4'b1000, 4'b0000});
    irq = 4'b0000;
    @(posedge clk); #1;
    check("rst_pre_valid", {1'b1, 2'd3, 4'b1000, 4'b0000});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", 11'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_idle%0d", i), 11'b0);
    end

    // line held high through reset release counts as an edge
    rst_n = 1'b0;
    irq = 4'b0001;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("held_edge_pend", {1'b0, 2'd0, 4'b0001, 4'b0000});
    @(posedge clk); #1;
    check("held_edge_valid", {1'b1, 2'd0, 4'b0001, 4'b0000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/utim64_irq_sched.md
# utim64_irq_sched

Interrupt scheduler for the four comparator interrupt lines of the 64-bit user timer. Captures rising edges of each comparator IRQ into pending flags, applies a per-source mask, and arbitrates (fixed or round-robin priority) to present exactly one interrupt at a time to the interrupt controller over a valid/ack handshake. Sits in the iTIMER_CLOCK domain between the timer's `oIRQ_IRQ[3:0]` bus and the system IRQ fabric. Repeated events on a source are flagged in sticky overflow bits.

## Interface
Parameters: none (fixed at 4 sources).

Ports:
- iTIMER_CLOCK  in  1  block clock; all logic on rising edge
- inRESET  in  1  reset: asynchronous, active-low
- iIRQ  in  4  comparator IRQ lines, bit n = comparator n; synchronous to iTIMER_CLOCK
- iMASK  in  4  1 = source excluded from arbitration (edges still latched)
- iRR_MODE  in  1  0 = fixed priority (bit 0 highest), 1 = round-robin
- oIRQ_VALID  out  1  interrupt presented
- oIRQ_NUM  out  2  source number of presented interrupt; stable while oIRQ_VALID
- iIRQ_ACK  in  1  consumer accepts presented interrupt
- oPENDING  out  4  pending flags
- oOVERFLOW  out  4  sticky: edge arrived while source already pending
- iOVF_CLEAR  in  1  clears all oOVERFLOW bits

## Operation
- Edge detect: register b_irq_prev <= iIRQ each cycle; edge[n] = iIRQ[n] & ~b_irq_prev[n].
- Pending update per bit, each edge: set on edge[n]; clear when ack accepted for n (oIRQ_VALID & iIRQ_ACK & oIRQ_NUM==n). Simultaneous set and clear on same bit: set wins (new event stays pending, no overflow).
- Overflow: oOVERFLOW[n] set when edge[n] & pending[n] & not being cleared that cycle. iOVF_CLEAR clears all bits; simultaneous set on a bit wins over clear.
- Candidates = pending & ~iMASK.
- State machine, two states:
  - IDLE: oIRQ_VALID=0. If candidates != 0, select winner, latch oIRQ_NUM, go to WAIT_ACK.
  - WAIT_ACK: oIRQ_VALID=1. On iIRQ_ACK, clear pending[oIRQ_NUM], update RR pointer, go to IDLE. Masking the presented source in this state does not withdraw it.
- Fixed mode: winner = lowest-index candidate.
- Round-robin: pointer b_last (reset 3) = last acked source; search order b_last+1, +2, +3, +4 (mod 4). Pointer updates only on ack, in both modes. Mode change is evaluated at next arbitration.
- iIRQ_ACK while oIRQ_VALID=0 is ignored.

## Timing
- Reset values: oIRQ_VALID=0, oIRQ_NUM=0, oPENDING=0, oOVERFLOW=0, b_irq_prev=0, b_last=3, state IDLE. An iIRQ line held high through reset release is seen as an edge on the first clock.
- Latency: iIRQ[n] first sampled high at edge k -> oPENDING[n]=1 after edge k -> oIRQ_VALID=1 after edge k+1 (2 cycles), if IDLE and unmasked.
- Ack accepted at edge j -> oIRQ_VALID=0 and pending cleared after j; next interrupt earliest valid after j+1 (one idle cycle between grants).
- Back-to-back throughput: one interrupt per 2 cycles with iIRQ_ACK held high.
- Reset asserted mid-handshake: all state cleared immediately; pending events lost.

## Test plan
- Single event: pulse iIRQ=4'b0100 one cycle, mask 0 -> oPENDING=4'b0100 one cycle later, oIRQ_VALID=1, oIRQ_NUM=2 two cycles after edge; ack -> oPENDING=0, oIRQ_VALID=0 next cycle.
- Fixed priority: edges on all four simultaneously, iRR_MODE=0, ack held 1 -> grants 0,1,2,3, each VALID high one cycle separated by one idle cycle.
- Round-robin: after grant 2 acked, edges on 0,1,3 with iRR_MODE=1 -> grant order 3,0,1.
- Mask: iMASK=4'b0001, edge on 0 -> pending[0]=1, no VALID; clear mask -> VALID with NUM=0 two cycles... one cycle after mask clear.
- Overflow: second edge on source 1 before ack -> oOVERFLOW=4'b0010, stays after ack; iOVF_CLEAR -> 0. Edge on source 1 in same cycle as its ack -> pending[1] remains 1, oOVERFLOW unchanged.
- Reset mid-handshake: assert inRESET while VALID=1 -> all outputs 0 immediately; release with iIRQ low -> no VALID.
